// File: rtl/biquad_cascade_seq.sv
// Cascade of SECTIONS direct-form-I biquads sharing one multiplier/accumulator.
// Sequencing is internal; the coefficient bank is writable only while idle.
module biquad_cascade_seq #(
  parameter int N        = 24,
  parameter int F        = 14,
  parameter int SECTIONS = 2,
  parameter int AW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  input  logic          clr,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [N-1:0]  coef_wdata,
  output logic          coef_err,
  output logic          ovf,
  output logic [1:0]    dbg_state
);
  localparam int NC   = 5 * SECTIONS;
  localparam int KW   = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam int ACCW = N + 4;
  localparam int WW   = 2 * N + 1;

  localparam logic signed [N-1:0]    ONE     = {{(N-F-1){1'b0}}, 1'b1, {F{1'b0}}};
  localparam logic signed [WW-1:0]   ACC_MAX = {{(N-2){1'b0}}, {(N+3){1'b1}}};
  localparam logic signed [WW-1:0]   ACC_MIN = {{(N-2){1'b1}}, {(N+3){1'b0}}};
  localparam logic signed [ACCW-1:0] Y_MAX   = {5'b00000, {(N-1){1'b1}}};
  localparam logic signed [ACCW-1:0] Y_MIN   = {5'b11111, {(N-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_STORE = 2'd2} state_t;

  state_t                 state, state_nxt;
  logic [KW-1:0]          k;
  logic [2:0]             i;
  logic signed [ACCW-1:0] acc, acc_nxt;
  logic signed [N-1:0]    xcur;
  logic signed [N-1:0]    coef [NC];
  logic signed [N-1:0]    x1 [SECTIONS];
  logic signed [N-1:0]    x2 [SECTIONS];
  logic signed [N-1:0]    y1 [SECTIONS];
  logic signed [N-1:0]    y2 [SECTIONS];
  logic signed [N-1:0]    c_op, d_op, y_sat;
  logic signed [2*N-1:0]  prod;
  logic signed [WW-1:0]   sum_w;
  logic [AW-1:0]          cidx;
  logic                   sat, last_sec, addr_ok;

  // Operand selection: coefficient 5*k+i paired with x, x1, x2, y1, y2.
  always_comb begin
    cidx     = AW'(5 * 32'(k) + 32'(i));
    c_op     = coef[cidx];
    last_sec = (32'(k) == SECTIONS - 1);
    addr_ok  = (32'(coef_addr) < NC);
    case (i)
      3'd0:    d_op = xcur;
      3'd1:    d_op = x1[k];
      3'd2:    d_op = x2[k];
      3'd3:    d_op = y1[k];
      3'd4:    d_op = y2[k];
      default: d_op = '0;
    endcase
  end

  // Floor-scaled product added into an accumulator that clamps instead of wrapping.
  always_comb begin
    prod  = c_op * d_op;
    sum_w = WW'(acc) + WW'(prod >>> F);
    if (sum_w > ACC_MAX)      acc_nxt = ACC_MAX[ACCW-1:0];
    else if (sum_w < ACC_MIN) acc_nxt = ACC_MIN[ACCW-1:0];
    else                      acc_nxt = sum_w[ACCW-1:0];
  end

  always_comb begin
    sat = 1'b1;
    if (acc > Y_MAX)      y_sat = Y_MAX[N-1:0];
    else if (acc < Y_MIN) y_sat = Y_MIN[N-1:0];
    else begin
      y_sat = acc[N-1:0];
      sat   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (in_valid) state_nxt = S_MAC;
        S_MAC:   if (i == 3'd4) state_nxt = S_STORE;
        S_STORE: state_nxt = last_sec ? S_IDLE : S_MAC;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Handshake: a sample transfers on a rising edge where in_valid and in_ready are both
  // high; in_ready is high only in IDLE, so a source asserting in_valid while busy must
  // hold it until the transfer.
  always_comb begin
    in_ready  = (state == S_IDLE);
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k         <= '0;
      i         <= '0;
      acc       <= '0;
      xcur      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      coef_err  <= 1'b0;
      ovf       <= 1'b0;
      for (int j = 0; j < NC; j++) coef[j] <= (j % 5 == 0) ? ONE : '0;
      for (int j = 0; j < SECTIONS; j++) begin
        x1[j] <= '0;
        x2[j] <= '0;
        y1[j] <= '0;
        y2[j] <= '0;
      end
    end else if (clr) begin
      k         <= '0;
      i         <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      ovf       <= 1'b0;
      for (int j = 0; j < SECTIONS; j++) begin
        x1[j] <= '0;
        x2[j] <= '0;
        y1[j] <= '0;
        y2[j] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      if (coef_we) begin
        if (state == S_IDLE && addr_ok) coef[coef_addr] <= coef_wdata;
        else                            coef_err <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            xcur <= in_data;
            k    <= '0;
            i    <= '0;
            acc  <= '0;
          end
        end
        S_MAC: begin
          acc <= acc_nxt;
          i   <= i + 3'd1;
        end
        S_STORE: begin
          x2[k] <= x1[k];
          x1[k] <= xcur;
          y2[k] <= y1[k];
          y1[k] <= y_sat;
          xcur  <= y_sat;
          acc   <= '0;
          i     <= '0;
          if (sat) ovf <= 1'b1;
          if (last_sec) begin
            out_valid <= 1'b1;
            out_data  <= y_sat;
          end else begin
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_biquad_cascade_seq.sv
// Directed bench for biquad_cascade_seq: hand-computed vectors plus a small
// bit-exact reference model for the impulse-response run.
module tb_biquad_cascade_seq;
  localparam int N  = 24;
  localparam int F  = 14;
  localparam int S  = 2;
  localparam int AW = 4;
  localparam longint YMAX = 8388607;
  localparam longint YMIN = -8388608;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic          clr = 1'b0;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [N-1:0]  coef_wdata = '0;
  logic          coef_err;
  logic          ovf;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  longint mc [5*S];
  longint mx1 [S];
  longint mx2 [S];
  longint my1 [S];
  longint my2 [S];
  longint movf;

  // clock / reset
  always #5 clk = ~clk;

  biquad_cascade_seq #(.N(N), .F(F), .SECTIONS(S), .AW(AW)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data), .clr(clr),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(coef_err), .ovf(ovf), .dbg_state(dbg_state)
  );

  always @(posedge clk) if (reset && in_valid && in_ready) hs_cnt <= hs_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model
  task automatic model_reset_coefs();
    for (int j = 0; j < 5*S; j++) mc[j] = (j % 5 == 0) ? 16384 : 0;
  endtask

  task automatic model_clear();
    for (int j = 0; j < S; j++) begin
      mx1[j] = 0; mx2[j] = 0; my1[j] = 0; my2[j] = 0;
    end
    movf = 0;
  endtask

  task automatic model_step(input longint x, output longint y);
    longint v, sum, p, ys;
    longint d [5];
    v = x;
    for (int k = 0; k < S; k++) begin
      d[0] = v; d[1] = mx1[k]; d[2] = mx2[k]; d[3] = my1[k]; d[4] = my2[k];
      sum = 0;
      for (int i = 0; i < 5; i++) begin
        p = (mc[5*k+i] * d[i]) >>> F;
        sum = sum + p;
        if (sum > 134217727) sum = 134217727;
        if (sum < -134217728) sum = -134217728;
      end
      ys = sum;
      if (sum > YMAX) begin ys = YMAX; movf = 1; end
      if (sum < YMIN) begin ys = YMIN; movf = 1; end
      mx2[k] = mx1[k]; mx1[k] = v; my2[k] = my1[k]; my1[k] = ys;
      v = ys;
    end
    y = v;
  endtask

  // driver tasks
  task automatic write_coef(input int addr, input longint val);
    logic [63:0] vb;
    vb = val;
    @(negedge clk);
    coef_we = 1'b1; coef_addr = addr[AW-1:0]; coef_wdata = vb[N-1:0];
    @(negedge clk);
    coef_we = 1'b0;
    if (addr < 5*S) mc[addr] = val;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    model_clear();
  endtask

  task automatic start_sample(input longint x);
    int t;
    logic [63:0] xb;
    xb = x;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 60) begin @(negedge clk); t++; end
    if (t >= 60) check("ready_timeout", 0, 1);
    in_valid = 1'b1; in_data = xb[N-1:0];
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output longint y, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (lat >= 60) begin check("out_timeout", 0, 1); break; end
      @(posedge clk);
      lat++;
    end
    y = $signed(out_data);
  endtask

  task automatic send_check(input string tag, input longint x, input longint exp, input bit chk_lat);
    longint y;
    int lat;
    start_sample(x);
    wait_out(y, lat);
    check(tag, y, exp);
    if (chk_lat) check({tag, "_lat"}, lat, 12);
  endtask

  initial begin
    longint y, ym;
    int lat, hs0;
    bit busy_ok, got_ov;
    longint hand [3];
    hand[0] = 3; hand[1] = 11; hand[2] = 21;
    model_reset_coefs();
    model_clear();

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", $signed(out_data), 0);
    check("rst_coef_err", coef_err, 0);
    check("rst_ovf", ovf, 0);
    check("rst_state", dbg_state, 0);

    // default pass-through
    send_check("t1_pos", 100, 100, 1);
    send_check("t1_neg", -5, -5, 1);
    send_check("t1_max", YMAX, YMAX, 1);
    check("t1_ovf", ovf, 0);

    // impulse response of a resonant low-pass in section 0
    pulse_clr();
    write_coef(0, 3); write_coef(1, 6); write_coef(2, 3);
    write_coef(3, 32112); write_coef(4, -15736);
    for (int n = 0; n < 64; n++) begin
      longint x;
      x = (n == 0) ? 16384 : 0;
      start_sample(x);
      wait_out(y, lat);
      model_step(x, ym);
      check($sformatf("t2_model_%0d", n), y, ym);
      if (n < 3) check($sformatf("t2_hand_%0d", n), y, hand[n]);
    end
    check("t2_ovf", ovf, movf);

    // saturation, then clr clears ovf and delay lines
    pulse_clr();
    write_coef(0, YMAX);
    for (int j = 1; j < 5; j++) write_coef(j, 0);
    send_check("t3_sat", YMAX, YMAX, 0);
    check("t3_ovf_set", ovf, 1);
    write_coef(0, 0); write_coef(1, 16384);
    pulse_clr();
    check("t3_ovf_clr", ovf, 0);
    send_check("t3_delay_zero", 0, 0, 0);
    write_coef(0, 16384); write_coef(1, 0);

    // held in_valid is consumed once per sample
    @(negedge clk);
    hs0 = hs_cnt;
    in_valid = 1'b1; in_data = 24'd7;
    @(posedge clk);
    busy_ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (in_ready || out_valid) busy_ok = 1'b0;
    end
    check("t4_busy", busy_ok, 1);
    @(negedge clk);
    check("t4_out_valid", out_valid, 1);
    check("t4_ready_idle", in_ready, 1);
    check("t4_out_data", $signed(out_data), 7);
    check("t4_hs_one", hs_cnt - hs0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_hs_two", hs_cnt - hs0, 2);
    check("t4_ready_busy", in_ready, 0);
    wait_out(y, lat);
    check("t4_second", y, 7);
    in_data = 24'd0;
    repeat (3) @(negedge clk);
    check("t4_hold", $signed(out_data), 7);
    check("t4_pulse", out_valid, 0);

    // write attempts while busy or out of range
    start_sample(50);
    repeat (2) @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 24'd32768;
    @(negedge clk);
    coef_we = 1'b0;
    check("t5_err_busy", coef_err, 1);
    @(negedge clk);
    check("t5_err_pulse", coef_err, 0);
    wait_out(y, lat);
    check("t5_out_busy", y, 50);
    send_check("t5_coef_kept", 50, 50, 0);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'd10; coef_wdata = 24'd32768;
    @(negedge clk);
    coef_we = 1'b0;
    check("t5_err_addr", coef_err, 1);
    send_check("t5_no_write", 9, 9, 0);

    // write and handshake in the same cycle: new coefficient applies
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 24'd32768;
    in_valid = 1'b1; in_data = 24'd21;
    @(posedge clk);
    #1 coef_we = 1'b0; in_valid = 1'b0;
    wait_out(y, lat);
    check("t5_same_cycle", y, 42);
    check("t5_same_lat", lat, 12);

    // reset in the middle of section 1
    start_sample(123);
    repeat (9) @(negedge clk);
    check("t6_in_sec1", dbg_state, 1);
    reset = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_out_data", $signed(out_data), 0);
    check("t6_ovf", ovf, 0);
    check("t6_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset_coefs();
    model_clear();
    got_ov = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) got_ov = 1'b1;
    end
    check("t6_no_out", got_ov, 0);
    send_check("t6_after", 100, 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
